muldiv_sequencer: RTL

//   Sequences the multi-cycle MULTU/DIVU datapath. One operation at a time.

---
 rtl/muldiv_sequencer.sv | 98 +++++++++
 1 files changed

// File: rtl/muldiv_sequencer.sv
// Control sequencer for the iterative MULTU/DIVU datapath: load, WIDTH steps, HiLo write.
// Holds off MFHI/MFLO and further multiply/divide requests while an operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [5:0]       funct,
  output logic             op_ready,
  output logic             md_load,
  output logic             md_step,
  output logic             md_is_div,
  output logic [CNT_W-1:0] md_iter,
  output logic             hilo_we,
  output logic             done,
  output logic             busy,
  output logic             stall
);

  localparam logic [5:0] FUNCT_MULTU = 6'd25;
  localparam logic [5:0] FUNCT_DIVU  = 6'd27;
  localparam logic [5:0] FUNCT_MFHI  = 6'd16;
  localparam logic [5:0] FUNCT_MFLO  = 6'd18;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    WRITE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             isDiv_q, isDiv_d;
  logic             isMulDiv;
  logic             isMoveFrom;

  assign isMulDiv   = (funct == FUNCT_MULTU) || (funct == FUNCT_DIVU);
  assign isMoveFrom = (funct == FUNCT_MFHI) || (funct == FUNCT_MFLO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      isDiv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      isDiv_q <= isDiv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    isDiv_d = isDiv_q;
    case (state_q)
      IDLE: begin
        if (op_valid && isMulDiv) begin
          isDiv_d = (funct == FUNCT_DIVU);
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = RUN;
      end
      RUN: begin
        // The counter parks on the final index; LOAD clears it for the next operation.
        if (cnt_q == LAST_ITER) begin
          state_d = WRITE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign op_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign md_load   = (state_q == LOAD);
  assign md_step   = (state_q == RUN);
  assign md_iter   = cnt_q;
  assign hilo_we   = (state_q == WRITE);
  assign done      = (state_q == WRITE);
  assign md_is_div = isDiv_q;
  assign stall     = op_valid && busy && (isMulDiv || isMoveFrom);

endmodule
